// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states and
// the lane-offset width helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/lsu_bus_fsm_if.sv
// Core-request, core-response and data-bus signals of the load/store unit.
// master: the LSU itself. slave: the environment (core execute stage + bridge).
interface lsu_bus_fsm_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  // core request
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // core response
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // data bus
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic                bus_ack;
  logic [DATA_W-1:0]   bus_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, resp_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: alignment check, store strobes and data
// replication, load shift and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = off_w(DATA_W)
) (
  input  size_e               size,
  input  logic [OFF_W-1:0]    off,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic                misaligned,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata_lane,
  output logic [DATA_W-1:0]   rdata_fmt
);

  localparam int STRB_W = DATA_W / 8;

  // Addressed lane moved down to bit 0 before masking/extension.
  logic [DATA_W-1:0] shifted;
  assign shifted = rdata >> {off, 3'b000};

  // Per-size alignment rule, strobe pattern, store replication and load extension.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    misaligned = 1'b0;
    wstrb      = '0;
    wdata_lane = '0;
    rdata_fmt  = '0;
    unique case (size)
      SZ_B: begin
        wstrb      = STRB_W'(1) << off;
        wdata_lane = {STRB_W{wdata[7:0]}};
        if (is_unsigned) rdata_fmt = DATA_W'(shifted[7:0]);
        else             rdata_fmt = DATA_W'($signed(shifted[7:0]));
      end
      SZ_H: begin
        misaligned = off[0];
        wstrb      = STRB_W'(2'b11) << off;
        wdata_lane = {(DATA_W / 16){wdata[15:0]}};
        if (is_unsigned) rdata_fmt = DATA_W'(shifted[15:0]);
        else             rdata_fmt = DATA_W'($signed(shifted[15:0]));
      end
      SZ_W: begin
        misaligned = (off[1:0] != 2'b00);
        wstrb      = STRB_W'(4'hF) << off;
        wdata_lane = {(DATA_W / 32){wdata[31:0]}};
        if (is_unsigned) rdata_fmt = DATA_W'(shifted[31:0]);
        else             rdata_fmt = DATA_W'($signed(shifted[31:0]));
      end
      SZ_D: begin
        // A 32-bit bus cannot carry a doubleword at all.
        misaligned = (DATA_W == 32) || (off != '0);
        wstrb      = '1;
        wdata_lane = wdata;
        rdata_fmt  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_fsm.sv
// Load/store unit: accepts one core access at a time, runs it on a
// request/acknowledge bus with timeout, and returns a one-cycle response.
module lsu_bus_fsm
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic           cpu_clk,
  input logic           cpu_rst,
  lsu_bus_fsm_if.master io
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 2);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_idle;
  size_e             al_size;
  logic [OFF_W-1:0]  al_off;
  logic              al_uns;
  logic              al_misaligned;
  logic [STRB_W-1:0] al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              timeout_hit;

  // In IDLE the aligner judges the incoming request; afterwards it works on
  // the latched copy, so req_* changes during a transfer have no effect.
  assign in_idle = (state_q == IDLE);
  assign al_size = in_idle ? size_e'(io.req_size)         : size_q;
  assign al_off  = in_idle ? io.req_addr[OFF_W-1:0]       : addr_q[OFF_W-1:0];
  assign al_uns  = in_idle ? io.req_unsigned              : uns_q;

  lsu_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata       (wdata_q),
    .rdata       (io.bus_rdata),
    .misaligned  (al_misaligned),
    .wstrb       (al_wstrb),
    .wdata_lane  (al_wdata),
    .rdata_fmt   (al_rdata)
  );

  // The count of un-acked BUS cycles reaches the limit on this cycle.
  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));

  // Next-state, request latching, load capture and timeout counting.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          we_d    = io.req_we;
          size_d  = size_e'(io.req_size);
          uns_d   = io.req_unsigned;
          addr_d  = io.req_addr;
          wdata_d = io.req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = al_misaligned;
          state_d = al_misaligned ? RESP : BUS;
        end
      end
      BUS: begin
        if (io.bus_ack) begin
          // Ack beats a coincident timeout.
          if (!we_q) rdata_d = al_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers, all cleared by the asynchronous reset.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the state; bus fields are zero outside BUS so a
  // reset drops them immediately.
  always_comb begin
    io.stall      = io.req_valid && (state_q != RESP);
    io.resp_valid = (state_q == RESP);
    io.resp_err   = (state_q == RESP) && err_q;
    io.resp_rdata = (state_q == RESP) ? rdata_q : '0;
    io.bus_req    = (state_q == BUS);
    io.bus_we     = (state_q == BUS) && we_q;
    io.bus_addr   = '0;
    io.bus_wdata  = '0;
    io.bus_wstrb  = '0;
    if (state_q == BUS) begin
      io.bus_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (we_q) begin
        io.bus_wdata = al_wdata;
        io.bus_wstrb = al_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_fsm.sv
// Directed bench for lsu_bus_fsm (32-bit bus, timeout of 4 cycles). A
// transaction-level model predicts every cycle's outputs; a compare process
// checks them on the falling edge, and literal checks pin the model.
module tb_lsu_bus_fsm;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_stall, e_resp_valid, e_resp_err, e_bus_req, e_bus_we;
  logic [31:0] e_resp_rdata, e_bus_addr, e_bus_wdata;
  logic [3:0]  e_bus_wstrb;

  lsu_bus_fsm_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

  lsu_bus_fsm #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .io      (io)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model (spec rules as plain arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;              // no dword on a 32-bit bus
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
    logic [7:0] t;
    t = 8'((1 << nbytes(size)) - 1);
    t = t << addr[1:0];
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] sh, mask, v;
    int nb;
    nb = nbytes(size);
    sh = rd >> (8 * int'(addr[1:0]));
    if (nb >= 4) return sh;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = sh & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic exp_idle(input logic rv);
    e_stall      = rv;
    e_resp_valid = 1'b0;
    e_resp_err   = 1'b0;
    e_resp_rdata = '0;
    e_bus_req    = 1'b0;
    e_bus_we     = 1'b0;
    e_bus_addr   = '0;
    e_bus_wdata  = '0;
    e_bus_wstrb  = '0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge cpu_clk) begin
    if (chk_en) begin
      check("stall", io.stall, e_stall);
      check("resp_valid", io.resp_valid, e_resp_valid);
      check("bus_req", io.bus_req, e_bus_req);
      if (e_resp_valid) begin
        check("resp_err", io.resp_err, e_resp_err);
        check("resp_rdata", io.resp_rdata, e_resp_rdata);
      end
      if (e_bus_req) begin
        check("bus_we", io.bus_we, e_bus_we);
        check("bus_addr", io.bus_addr, e_bus_addr);
        check("bus_wstrb", io.bus_wstrb, e_bus_wstrb);
        if (e_bus_we) check("bus_wdata", io.bus_wdata, e_bus_wdata);
      end
    end
  end

  // One complete access. ack_at = BUS cycle index carrying bus_ack, -1 = never.
  // Returns the response, number of bus_req cycles, accept-to-response
  // latency and the bus fields seen in the first BUS cycle.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata,
                        output logic [31:0] got_rdata, output logic got_err,
                        output int nreq, output int lat,
                        output logic [31:0] got_addr, output logic [31:0] got_wdata,
                        output logic [3:0] got_strb);
    logic mis, acked, done;
    mis = m_misaligned(size, addr);
    acked = 1'b0; nreq = 0; lat = 0;
    got_addr = '0; got_wdata = '0; got_strb = '0;
    io.req_valid = 1'b1; io.req_we = we; io.req_size = size; io.req_unsigned = uns;
    io.req_addr = addr; io.req_wdata = wdata; io.bus_ack = 1'b0;
    exp_idle(1'b1);
    @(posedge cpu_clk); #1; lat = 1;
    if (!mis) begin
      for (int k = 0; k < TO + 8; k++) begin
        if (k > 0) begin
          // must be ignored while the transfer is in flight
          io.req_addr = addr ^ 32'h0000_0F00;
          io.req_wdata = ~wdata;
          io.req_unsigned = ~uns;
        end
        e_stall = 1'b1; e_resp_valid = 1'b0; e_bus_req = 1'b1; e_bus_we = we;
        e_bus_addr = {addr[31:2], 2'b00};
        e_bus_wstrb = we ? m_strb(size, addr) : 4'h0;
        e_bus_wdata = m_wdata(size, wdata);
        io.bus_ack = (k == ack_at);
        io.bus_rdata = (k == ack_at) ? rdata : (32'h0BAD_0000 | 32'(k));
        done = (k == ack_at) || (k + 1 == TO);
        @(negedge cpu_clk);
        if (io.bus_req) nreq++;
        if (k == 0) begin
          got_addr = io.bus_addr; got_wdata = io.bus_wdata; got_strb = io.bus_wstrb;
        end
        @(posedge cpu_clk); #1; lat++;
        io.bus_ack = 1'b0;
        if (done) begin
          acked = (k == ack_at);
          break;
        end
      end
    end
    e_bus_req = 1'b0; e_bus_we = 1'b0; e_stall = 1'b0; e_resp_valid = 1'b1;
    e_resp_err = mis || !acked;
    e_resp_rdata = (!e_resp_err && !we) ? m_load(rdata, addr, size, uns) : 32'h0;
    @(negedge cpu_clk);
    got_rdata = io.resp_rdata; got_err = io.resp_err;
    if (!io.resp_valid) lat = -1;
    @(posedge cpu_clk); #1;
    io.req_valid = 1'b0;
    exp_idle(1'b0);
  endtask

  task automatic idle(input int n);
    exp_idle(io.req_valid);
    repeat (n) begin
      @(posedge cpu_clk); #1;
    end
  endtask

  logic [31:0] r_data, r_addr, r_wdata;
  logic        r_err;
  logic [3:0]  r_strb;
  int          r_nreq, r_lat;

  initial begin
    io.req_valid = 1'b0; io.req_we = 1'b0; io.req_size = 2'd0; io.req_unsigned = 1'b0;
    io.req_addr = '0; io.req_wdata = '0; io.bus_ack = 1'b0; io.bus_rdata = '0;
    cpu_rst = 1'b1;
    #1;
    check("rst_stall", io.stall, 1'b0);
    check("rst_resp_valid", io.resp_valid, 1'b0);
    check("rst_resp_rdata", io.resp_rdata, 32'h0);
    check("rst_bus_req", io.bus_req, 1'b0);
    check("rst_bus_addr", io.bus_addr, 32'h0);
    check("rst_bus_wstrb", io.bus_wstrb, 4'h0);
    #20;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    exp_idle(1'b0);
    chk_en = 1'b1;
    idle(2);

    // Word load at 0x100, ack after 2 wait cycles.
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("wl_rdata", r_data, 32'hDEADBEEF);
    check("wl_err", r_err, 1'b0);
    check("wl_lat", r_lat, 4);
    check("wl_addr", r_addr, 32'h100);
    check("wl_strb", r_strb, 4'h0);
    idle(1);

    // Byte store 0xA5 at 0x203, immediate ack.
    access(1'b1, 2'd0, 1'b0, 32'h203, 32'h1234_56A5, 0, 32'hFFFF_FFFF,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("bs_strb", r_strb, 4'b1000);
    check("bs_wdata", r_wdata, 32'hA5A5A5A5);
    check("bs_addr", r_addr, 32'h200);
    check("bs_rdata", r_data, 32'h0);
    check("bs_lat", r_lat, 2);

    // Signed then unsigned half load at 0x102, back to back.
    access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1, 32'h8001_1234,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("hs_rdata", r_data, 32'hFFFF8001);
    access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, 32'h8001_1234,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("hu_rdata", r_data, 32'h00008001);

    // Misaligned word load: no bus cycle, error one cycle after accept.
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h1111_1111,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("mis_err", r_err, 1'b1);
    check("mis_nreq", r_nreq, 0);
    check("mis_lat", r_lat, 1);
    check("mis_rdata", r_data, 32'h0);
    idle(1);

    // Timeout with no ack, then ack on the last allowed cycle.
    access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, -1, 32'h0,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("to_nreq", r_nreq, 4);
    check("to_err", r_err, 1'b1);
    check("to_rdata", r_data, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, 32'h7777_0001,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("to4_nreq", r_nreq, 4);
    check("to4_err", r_err, 1'b0);
    check("to4_rdata", r_data, 32'h7777_0001);

    // Further lane patterns and illegal sizes.
    access(1'b1, 2'd1, 1'b0, 32'h002, 32'h1234_BEEF, 1, 32'h0,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("hst_strb", r_strb, 4'b1100);
    check("hst_wdata", r_wdata, 32'hBEEFBEEF);
    access(1'b0, 2'd0, 1'b0, 32'h001, 32'h0, 0, 32'h0000_8000,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("bl_rdata", r_data, 32'hFFFFFF80);
    access(1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 0, 32'h0,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("dw_err", r_err, 1'b1);
    access(1'b0, 2'd1, 1'b0, 32'h003, 32'h0, 0, 32'h0,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("hmis_err", r_err, 1'b1);
    access(1'b1, 2'd2, 1'b0, 32'h010, 32'hCAFE_F00D, 1, 32'h0,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("wst_strb", r_strb, 4'hF);
    check("wst_wdata", r_wdata, 32'hCAFEF00D);
    idle(1);

    // Asynchronous reset in the middle of a bus transfer.
    chk_en = 1'b0;
    io.req_valid = 1'b1; io.req_we = 1'b0; io.req_size = 2'd2; io.req_unsigned = 1'b0;
    io.req_addr = 32'h300; io.bus_ack = 1'b0;
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    check("rst_pre_busreq", io.bus_req, 1'b1);
    io.req_valid = 1'b0;
    #1 cpu_rst = 1'b1;
    #1;
    check("rst_mid_busreq", io.bus_req, 1'b0);
    check("rst_mid_stall", io.stall, 1'b0);
    check("rst_mid_resp", io.resp_valid, 1'b0);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    exp_idle(1'b0);
    chk_en = 1'b1;
    idle(1);
    access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 32'h1234_5678,
           r_data, r_err, r_nreq, r_lat, r_addr, r_wdata, r_strb);
    check("post_rst_rdata", r_data, 32'h1234_5678);
    check("post_rst_err", r_err, 1'b0);
    check("post_rst_lat", r_lat, 2);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_fsm.md
Name: lsu_bus_fsm

Overview:
- Parametrised load/store unit for the data-bus side of the CPU core.
- Generalises the fixed single-cycle data transfer (enable, address, write data, read data) to a variable-latency request/acknowledge bus.
- Adds byte/half/word(/dword) access with write strobes, sign/zero-extended loads, misalignment detection, bus timeout and a core stall output.
- Sits between the core's execute stage and the bridge; the core holds its request stable while stall is high.

Parameters:
- DATA_W, 32, bus and register data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT_CYC, 255, bus cycles to wait for bus_ack before an error; 0 disables the timeout.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core requests a memory access.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- stall  out  1  core must hold PC and request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  formatted load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or timeout.
- bus_req  out  1  bus request, held until bus_ack.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  request address with the low OFF_W bits cleared (OFF_W = log2(DATA_W/8)).
- bus_wdata  out  DATA_W  store data replicated into the addressed lane.
- bus_wstrb  out  DATA_W/8  byte write enables; all 0 for reads.
- bus_ack  in  1  bus completes the transfer this cycle.
- bus_rdata  in  DATA_W  read data, sampled when bus_ack is high.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All outputs 0, including resp_rdata.
  - Timeout counter cleared.
  - bus_req drops immediately, even mid-transfer.
- stall is combinational: req_valid && state != RESP.
  - Low in the RESP cycle, so the core advances exactly once.
- IDLE:
  - When req_valid is high, latch we, size, unsigned, addr and wdata.
  - Misaligned or illegal size (half with addr[0]; word with addr[1:0] != 0; dword with addr[2:0] != 0 or DATA_W=32): go to RESP with err=1 and issue no bus cycle.
  - Otherwise go to BUS.
- BUS:
  - bus_req=1; bus_addr, bus_we, bus_wdata and bus_wstrb come from the latched registers and are stable for the whole request.
  - On bus_ack: a load captures the formatted bus_rdata; go to RESP with err=0.
  - Counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYC: drop bus_req and go to RESP with err=1.
  - If bus_ack and timeout coincide in the same cycle, ack wins.
- RESP: resp_valid=1 and resp_err valid for exactly one cycle, then IDLE.
  - A new req_valid in the following IDLE cycle is a new request (back-to-back allowed).
- Latency: accept in cycle n, bus_req from n+1, ack at n+1 gives resp_valid at n+2. Minimum 3 cycles per access; a misaligned access responds at n+1.
- Store lane formatting, with off = addr[OFF_W-1:0]:
  - byte: wstrb = 1 << off, data replicated in every byte lane.
  - half: wstrb = 2'b11 << off, data replicated in every halfword.
  - word: wstrb = 4'hF << off.
  - dword: all strobes set.
- Load formatting: shift bus_rdata right by off*8, mask to the size, then sign- or zero-extend to DATA_W.
- Inputs are ignored outside IDLE; a change to req_* during BUS has no effect.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - state enum IDLE/BUS/RESP;
  - function off_w(DATA_W).
- One combinational sub-module, lsu_align, contains the misalignment check, strobe and write-data replication, and load shift/extend. The top keeps the FSM, request latches and timeout counter.

Test Plan:
- Word load at 0x100, bus_ack after 2 wait cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x100 and wstrb=0; resp_valid at accept+4; resp_rdata=0xDEADBEEF, err=0; stall falls in the RESP cycle.
- Byte store 0xA5 at 0x203 -> wstrb=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200; resp_rdata=0.
- Signed half load at 0x102 with bus_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; the same access with req_unsigned=1 -> 0x00008001.
- Word load at 0x101 -> no bus_req ever; resp_valid and resp_err=1 one cycle after accept.
- TIMEOUT_CYC=4 with bus_ack never asserted -> bus_req high for exactly 4 cycles, then resp_err=1. A second run with ack on the 4th cycle -> err=0.
- cpu_rst pulsed mid-BUS -> bus_req and stall (given req_valid low) go to 0 asynchronously; after release, a new word load completes normally.
